mux_rr_sched: RTL
=================

Name: mux_rr_sched

Overview:
Round-robin scheduler that shares one mux_16X1 between 16 requesters. It arbitrates the request lines, drives the mux `sel` and holds it stable for one valid/ready transfer per grant. A timeout keeps a stalled consumer from freezing the mux. Sits directly in front of mux_16X1; `sel` connects to mux `sel`, `valid` qualifies mux output `y` for the downstream consumer.

Parameters:
N, 16, number of requesters / mux inputs (fixed at 16 for mux_16X1)
SELW, 4, select width, log2(N)
TIMEOUT, 15, max cycles a grant waits for `ready` before abandonment; 0 disables timeout
CNTW, 8, timeout counter width; TIMEOUT must be < 2**CNTW

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  scheduler enable; no new grants while low
req  input  16  per-requester request, bit i = mux input i
ready  input  1  downstream consumer accepts `y` this cycle
sel  output  4  mux select, registered
grant  output  16  one-hot grant, equals 1<<sel when valid, else 0
valid  output  1  `sel`/`y` valid, transfer when valid&ready
timeout  output  1  one-cycle pulse: grant abandoned due to timeout
busy  output  1  high in GRANT state

Behaviour:
- Reset (async, any time incl. mid-grant): state=IDLE, sel=0, grant=0, valid=0, timeout=0, busy=0, pointer ptr=0, counter=0. Pending transfer is dropped, with no pulse.
- ptr = highest-priority index. Search order: ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16 wrap).
- pick = first index in search order with req bit set. The combinational search uses current `req` and `ptr`.
- IDLE: if en & (req!=0): next edge sel<=pick, grant<=1<<pick, valid<=1, counter<=0, go to GRANT. Else remain, outputs 0. Latency: request to valid is 1 cycle.
- GRANT: sel/grant/valid held constant until exit.
  - The grant is committed: a requester dropping `req` does not revoke it.
  - Counter increments each cycle without a handshake.
- Exit on handshake (valid&ready): ptr<=sel+1 mod 16 (15 wraps to 0). Same edge:
  - if en & req!=0, re-arbitrate using the new ptr and stay in GRANT with the new sel. This gives back-to-back grants with no bubble.
  - else go to IDLE with valid=0 and grant=0.
- Exit on timeout (TIMEOUT!=0, counter==TIMEOUT-1, no ready): timeout pulses 1 on the next cycle. ptr advances exactly as for a handshake, and re-arbitration follows the same rule. Handshake has priority if ready is high in the timeout cycle, and then there is no pulse.
- Served requester gets lowest priority next round. If it is the only requester, it is re-granted.
- en low in GRANT: the current grant completes or times out, then the block goes to IDLE. en affects only new grants.
- sel never changes while valid=1 and ready=0 (other than by timeout).
- busy = (state==GRANT). grant and valid are always consistent with sel.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1), N, SELW defaults.
- One natural sub-module, rr_pick16. It is combinational and takes req[15:0] and ptr[3:0], returning pick[3:0] and any. It is implemented by rotate right by ptr, priority-encode the lowest set bit, then add ptr mod 16.

Test Plan:
- Reset mid-grant: req=16'h0010, ready=0, assert rst after 3 cycles -> sel=0, valid=0, grant=0 immediately (async); no timeout pulse.
- Single request: en=1, req=16'h0020, ready=1 -> valid=1, sel=5 one cycle later. With req held, sel stays 5 on every cycle (sole requester re-granted).
- Round-robin with wrap: req=16'h8003, ready=1, ptr=0 -> sel sequence 0,1,15,0,1,15. Drive mux in=16'b1010111100001010 -> y sequence 0,1,1,0,1,1.
- Backpressure: req=16'h0100, ready=0 for 5 cycles, then 1 -> sel=8 stable for 6 cycles. Exactly one transfer; no timeout.
- Timeout: TIMEOUT=15, req=16'h0006, ready=0 -> sel=1 for 15 cycles, then timeout pulses 1 cycle and sel=2.
- Boundary cases:
  - Revoke: grant sel=3, then req drops to 0 with ready=0; valid stays 1 until ready, then IDLE.
  - en low: with en=0 and req=16'hFFFF, valid stays 0.

Source files
------------

// File: rtl/mux_rr_sched_pkg.sv
// ============================================================================
// mux_rr_sched_pkg : shared types and defaults for the mux_16X1 scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_rr_sched_pkg;
  localparam int N_DEF    = 16;
  localparam int SELW_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/mux_rr_sched_pick.sv
// ============================================================================
// rr_pick16 : first set request at or after ptr, wrapping modulo 16
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick16
  import mux_rr_sched_pkg::*;
(
  input  logic [N_DEF-1:0]    req,
  input  logic [SELW_DEF-1:0] ptr,
  output logic [SELW_DEF-1:0] pick,
  output logic                any
);

  logic [N_DEF-1:0]    rot;
  logic [SELW_DEF-1:0] idx;

  always_comb begin
    // Rotate so ptr lands at bit 0; the lowest set bit is then the winner.
    rot = N_DEF'({req, req} >> ptr);
    idx = '0;
    for (int i = N_DEF - 1; i >= 0; i--) begin
      if (rot[i]) idx = SELW_DEF'(i);
    end
    pick = idx + ptr;
    any  = |req;
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_sched.sv
// ============================================================================
// mux_rr_sched : round-robin select generator for a shared 16:1 mux
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int SELW    = SELW_DEF,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic            ready,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    grant,
  output logic            valid,
  output logic            timeout,
  output logic            busy
);

  localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [SELW-1:0] ptr_arb;
  logic [SELW-1:0] pick;
  logic            any;
  logic            to_hit;
  logic            done;

  // While granted, the search already uses the pointer that follows the
  // current winner, so a handshake can re-grant on the same edge.
  assign ptr_arb = (state_q == GRANT) ? sel_q + SELW'(1) : ptr_q;
  assign to_hit  = (TIMEOUT != 0) && (cnt_q == CNTW'(TO_LAST)) && !ready;
  assign done    = ready || to_hit;

  rr_pick16 u_pick (
    .req  (req),
    .ptr  (ptr_arb),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en && any) begin
          state_d = GRANT;
          sel_d   = pick;
          grant_d = N'(1) << pick;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (done) begin
          ptr_d     = ptr_arb;
          timeout_d = !ready;
          cnt_d     = '0;
          if (en && any) begin
            sel_d   = pick;
            grant_d = N'(1) << pick;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q == GRANT);

endmodule

`default_nettype wire
